// File: rtl/key_nco_multi.sv
// rtl/key_nco_multi.sv - key-controlled multi-channel NCO with debounced up/down/preset keys
// Shared frequency word steps on key events; N_CH phase accumulators run at binary multiples.
module key_nco_multi #(
    parameter int          ACC_W       = 32,
    parameter int          N_CH        = 2,
    parameter int          CH_SHIFT    = 2,
    parameter int          SCAN_CYCLES = 1_000_000,
    parameter int unsigned STEP        = 429496,
    parameter int unsigned FW_RESET    = 429496,
    parameter int unsigned FW_MIN      = 429496,
    parameter int unsigned FW_MAX      = 4294967,
    parameter int          WRAP_MODE   = 0,
    parameter int          REPEAT_DLY  = 25,
    parameter int          REPEAT_PER  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       key_in,
    output logic [ACC_W-1:0] fre_word,
    output logic             fw_upd,
    output logic [N_CH-1:0]  clk_out
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int HOLD_W = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
    localparam int RPT_W  = (REPEAT_PER > 1) ? $clog2(REPEAT_PER) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_PER - 1);

    localparam logic [ACC_W-1:0] STEP_W  = ACC_W'(STEP);
    localparam logic [ACC_W-1:0] RESET_W = ACC_W'(FW_RESET);
    localparam logic [ACC_W-1:0] MIN_W   = ACC_W'(FW_MIN);
    localparam logic [ACC_W-1:0] MAX_W   = ACC_W'(FW_MAX);
    localparam logic [ACC_W:0]   DN_FLOOR = {1'b0, MIN_W} + {1'b0, STEP_W};
    localparam bit               WRAP    = (WRAP_MODE != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RPT
    } key_state_t;

    logic [2:0]        key_s1;
    logic [2:0]        key_s2;
    logic [SCAN_W-1:0] scan_cnt;
    logic              tick;
    logic              pre_smp;
    logic              ev_pre;
    logic [1:0]        ev_key;
    logic [1:0]        pressed;

    key_state_t        key_st   [2];
    logic [HOLD_W-1:0] hold_cnt [2];
    logic [RPT_W-1:0]  rpt_cnt  [2];

    logic [ACC_W-1:0]  acc [N_CH];
    logic [ACC_W:0]    sum_up;
    logic [ACC_W-1:0]  fw_next;

    assign tick    = (scan_cnt == SCAN_LAST);
    assign pressed = ~key_s2[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1   <= 3'b111;
            key_s2   <= 3'b111;
            scan_cnt <= '0;
        end else begin
            key_s1   <= key_in;
            key_s2   <= key_s1;
            scan_cnt <= tick ? '0 : scan_cnt + SCAN_W'(1);
        end
    end

    // Up/down repeat FSMs; hold_cnt counts ticks elapsed since the press event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_smp <= 1'b1;
            ev_pre  <= 1'b0;
            ev_key  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                key_st[i]   <= ST_IDLE;
                hold_cnt[i] <= '0;
                rpt_cnt[i]  <= '0;
            end
        end else begin
            ev_pre <= tick && pre_smp && !key_s2[2];
            if (tick) begin
                pre_smp <= key_s2[2];
            end
            for (int i = 0; i < 2; i++) begin
                ev_key[i] <= 1'b0;
                if (tick) begin
                    case (key_st[i])
                        ST_IDLE: begin
                            if (pressed[i]) begin
                                ev_key[i]   <= 1'b1;
                                key_st[i]   <= ST_HOLD;
                                hold_cnt[i] <= '0;
                            end
                        end
                        ST_HOLD: begin
                            if (!pressed[i]) begin
                                key_st[i] <= ST_IDLE;
                            end else if (hold_cnt[i] == HOLD_LAST) begin
                                ev_key[i]  <= 1'b1;
                                key_st[i]  <= ST_RPT;
                                rpt_cnt[i] <= '0;
                            end else begin
                                hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                            end
                        end
                        ST_RPT: begin
                            if (!pressed[i]) begin
                                key_st[i] <= ST_IDLE;
                            end else if (rpt_cnt[i] == RPT_LAST) begin
                                ev_key[i]  <= 1'b1;
                                rpt_cnt[i] <= '0;
                            end else begin
                                rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
                            end
                        end
                        default: key_st[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_comb begin
        sum_up  = {1'b0, fre_word} + {1'b0, STEP_W};
        fw_next = fre_word;
        if (ev_pre) begin
            fw_next = RESET_W;
        end else if (ev_key[0] && !ev_key[1]) begin
            if (sum_up > {1'b0, MAX_W}) begin
                fw_next = WRAP ? MIN_W : MAX_W;
            end else begin
                fw_next = sum_up[ACC_W-1:0];
            end
        end else if (ev_key[1] && !ev_key[0]) begin
            if ({1'b0, fre_word} < DN_FLOOR) begin
                fw_next = WRAP ? MAX_W : MIN_W;
            end else begin
                fw_next = fre_word - STEP_W;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fre_word <= RESET_W;
            fw_upd   <= 1'b0;
        end else begin
            fre_word <= fw_next;
            fw_upd   <= (fw_next != fre_word);
        end
    end

    // Accumulators are never cleared on a word change, keeping output phase continuous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_out <= '0;
            for (int k = 0; k < N_CH; k++) begin
                acc[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                acc[k]     <= acc[k] + (fre_word << (k * CH_SHIFT));
                clk_out[k] <= acc[k][ACC_W-1];
            end
        end
    end

endmodule
